// File: rtl/uart_receiver_sv.sv
// rtl/uart_receiver_sv.sv - 8N1/8N2 UART receiver with valid/ack byte handshake
// Optional define UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_receiver_sv #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] comp,
    input  logic [1:0]  stop_sel,
    input  logic        rec_en,
    input  logic        uart_rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        rx_frame_err,
    output logic        rx_overrun
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] LAG = 16'd1;
`else
    localparam logic [15:0] LAG = 16'd0;
`endif

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [15:0]            comp_l;
    logic [15:0]            cnt;
    logic [15:0]            target;
    logic                   stop2;
    logic [2:0]             bit_idx;
    logic                   stop_idx;
    logic [7:0]             shreg;
    logic                   hit;
    logic                   bit_val;
    state_t                 state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync <= '1;
        else         sync <= {sync[SYNC_STAGES-2:0], uart_rx};
    end

    assign rx_s = sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    // hist[1] and hist[0] hold rx_s at P-1 and P when cnt reaches P+1
    logic [1:0] hist;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) hist <= 2'b11;
        else         hist <= {hist[0], rx_s};
    end

    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        target = (state == START) ? {1'b0, comp_l[15:1]} : comp_l - 16'd1;
        hit    = (cnt == target + LAG);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            comp_l       <= '0;
            stop2        <= 1'b0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            if (rx_ack && rx_valid) rx_valid <= 1'b0;

            if (!rec_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rx_s && comp >= 16'd8) begin
                            comp_l <= comp;
                            stop2  <= stop_sel[1];
                            cnt    <= '0;
                            state  <= START;
                        end
                    end
                    START: begin
                        if (hit) begin
                            if (bit_val) begin
                                state <= IDLE;
                            end else begin
                                cnt     <= LAG;
                                bit_idx <= '0;
                                state   <= DATA;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    DATA: begin
                        if (hit) begin
                            shreg[bit_idx] <= bit_val;
                            cnt            <= LAG;
                            bit_idx        <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                stop_idx <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    STOP: begin
                        if (hit) begin
                            if (!bit_val) begin
                                rx_frame_err <= 1'b1;
                                state        <= WAIT_HIGH;
                            end else if (stop2 && !stop_idx) begin
                                cnt      <= LAG;
                                stop_idx <= 1'b1;
                            end else begin
                                // returning at mid-stop leaves time to catch a back-to-back start edge
                                state <= IDLE;
                                if (!rx_valid || rx_ack) begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end else begin
                                    rx_overrun <= 1'b1;
                                end
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    WAIT_HIGH: begin
                        if (rx_s) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver_sv.sv
// tb/tb_uart_receiver_sv.sv - directed self-checking bench for uart_receiver_sv
module tb_uart_receiver_sv;

`ifdef UART_RX_MAJORITY_EN
    localparam int M = 1;
`else
    localparam int M = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] comp;
    logic [1:0]  stop_sel;
    logic        rec_en;
    logic        uart_rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        rx_frame_err;
    logic        rx_overrun;

    int tests = 0;
    int fails = 0;
    int fe_cnt, ov_cnt, rise_cnt, rise_tick, tk, ack_tick;
    bit auto_ack, valid_q;
    logic [7:0] got[$];

    uart_receiver_sv #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .comp         (comp),
        .stop_sel     (stop_sel),
        .rec_en       (rec_en),
        .uart_rx      (uart_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clk period; outputs observed here reflect the preceding rising edge.
    task automatic tick();
        @(negedge clk);
        tk++;
        if (rx_frame_err) fe_cnt++;
        if (rx_overrun) ov_cnt++;
        if (rx_valid && !valid_q) begin
            rise_cnt++;
            if (rise_tick < 0) rise_tick = tk;
        end
        valid_q = rx_valid;
        if (auto_ack && rx_valid && !rx_ack) begin
            got.push_back(rx_data);
            rx_ack = 1'b1;
        end else begin
            rx_ack = (tk == ack_tick);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            uart_rx = 1'b1;
        end
    endtask

    // kind 1: resetn pulse at abort_at, kind 2: rec_en pulse; line forced high afterwards
    task automatic send_frame(input logic [7:0] b, input int c, input int nstop,
                              input bit bad2, input int abort_at, input int kind);
        bit   aborted;
        logic v;
        aborted = 1'b0;
        tk = -1;
        for (int i = 0; i < 9 + nstop; i++) begin
            for (int j = 0; j < c; j++) begin
                tick();
                if (tk == abort_at) begin
                    aborted = 1'b1;
                    if (kind == 1) resetn = 1'b0;
                    else           rec_en = 1'b0;
                end
                if (aborted && tk == abort_at + 3) begin
                    resetn = 1'b1;
                    rec_en = 1'b1;
                end
                if (i == 0)                 v = 1'b0;
                else if (i <= 8)            v = b[i-1];
                else if (i == 10 && bad2)   v = 1'b0;
                else                        v = 1'b1;
                uart_rx = aborted ? 1'b1 : v;
            end
        end
    endtask

    task automatic do_ack();
        ack_tick = tk + 1;
        tick();
        tick();
        ack_tick = -100;
    endtask

    initial begin
        resetn = 1'b0; rec_en = 1'b1; uart_rx = 1'b1; rx_ack = 1'b0;
        comp = 16'd434; stop_sel = 2'b00;
        auto_ack = 1'b0; valid_q = 1'b0; ack_tick = -100; tk = 0;
        fe_cnt = 0; ov_cnt = 0; rise_cnt = 0; rise_tick = -1;
        repeat (3) tick();
        check("reset_data", rx_data, 8'h00);
        check("reset_valid", rx_valid, 1'b0);
        check("reset_ferr", rx_frame_err, 1'b0);
        check("reset_ovr", rx_overrun, 1'b0);
        resetn = 1'b1;
        idle(5);

        // 0xA5 at comp 434: delivery at 2 sync + 2 + 217 + 9*434 (+1 with majority)
        send_frame(8'hA5, 434, 1, 1'b0, -1, 0);
        idle(20);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid", rx_valid, 1'b1);
        check("a5_latency", rise_tick, 4 + 217 + 9 * 434 + M);
        do_ack();
        check("a5_ack_clears", rx_valid, 1'b0);

        // back-to-back, two stop bits, immediate ack
        comp = 16'd64; stop_sel = 2'b10; auto_ack = 1'b1;
        got.delete(); fe_cnt = 0; ov_cnt = 0;
        send_frame(8'h00, 64, 2, 1'b0, -1, 0);
        send_frame(8'hFF, 64, 2, 1'b0, -1, 0);
        send_frame(8'h3C, 64, 2, 1'b0, -1, 0);
        idle(200);
        auto_ack = 1'b0;
        check("b2b_count", got.size(), 3);
        check("b2b_byte0", got[0], 8'h00);
        check("b2b_byte1", got[1], 8'hFF);
        check("b2b_byte2", got[2], 8'h3C);
        check("b2b_ferr", fe_cnt, 0);
        check("b2b_ovr", ov_cnt, 0);
        check("b2b_valid", rx_valid, 1'b0);

        // 100-clk glitch is a false start
        comp = 16'd434; stop_sel = 2'b00; rise_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            uart_rx = 1'b0;
        end
        idle(600);
        check("glitch_no_valid", rise_cnt, 0);
        check("glitch_ferr", fe_cnt, 0);
        send_frame(8'hC3, 434, 1, 1'b0, -1, 0);
        idle(20);
        check("after_glitch_data", rx_data, 8'hC3);
        do_ack();

        // second stop bit low
        comp = 16'd40; stop_sel = 2'b10; fe_cnt = 0; rise_cnt = 0;
        send_frame(8'h5A, 40, 2, 1'b1, -1, 0);
        idle(100);
        check("ferr_pulse", fe_cnt, 1);
        check("ferr_no_valid", rise_cnt, 0);
        send_frame(8'h81, 40, 2, 1'b0, -1, 0);
        idle(50);
        check("after_ferr_data", rx_data, 8'h81);
        check("after_ferr_valid", rx_valid, 1'b1);
        check("after_ferr_cnt", fe_cnt, 1);
        do_ack();

        // overrun: two frames, no ack
        stop_sel = 2'b00; ov_cnt = 0;
        send_frame(8'h11, 40, 1, 1'b0, -1, 0);
        send_frame(8'h22, 40, 1, 1'b0, -1, 0);
        idle(50);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_pulse", ov_cnt, 1);
        check("ovr_valid", rx_valid, 1'b1);
        do_ack();

        // ack in the delivery cycle of the second frame
        ov_cnt = 0;
        send_frame(8'h11, 40, 1, 1'b0, -1, 0);
        ack_tick = 4 + 20 + 9 * 40 + M - 1;
        send_frame(8'h22, 40, 1, 1'b0, -1, 0);
        ack_tick = -100;
        idle(50);
        check("ackdel_data", rx_data, 8'h22);
        check("ackdel_valid", rx_valid, 1'b1);
        check("ackdel_no_ovr", ov_cnt, 0);
        do_ack();

        // resetn at bit 4 while a byte is held
        send_frame(8'h77, 40, 1, 1'b0, -1, 0);
        idle(50);
        rise_cnt = 0;
        send_frame(8'hE7, 40, 1, 1'b0, 220, 1);
        idle(500);
        check("rst_mid_data", rx_data, 8'h00);
        check("rst_mid_valid", rx_valid, 1'b0);
        check("rst_mid_no_byte", rise_cnt, 0);
        send_frame(8'h3E, 40, 1, 1'b0, -1, 0);
        idle(50);
        check("after_rst_data", rx_data, 8'h3E);
        do_ack();

        // rec_en dropped mid-frame keeps the held byte
        send_frame(8'h4B, 40, 1, 1'b0, -1, 0);
        idle(50);
        rise_cnt = 0; ov_cnt = 0;
        send_frame(8'hD2, 40, 1, 1'b0, 220, 2);
        idle(500);
        check("recen_data", rx_data, 8'h4B);
        check("recen_valid", rx_valid, 1'b1);
        check("recen_no_ovr", ov_cnt, 0);
        do_ack();
        check("recen_ack", rx_valid, 1'b0);
        send_frame(8'h69, 40, 1, 1'b0, -1, 0);
        idle(50);
        check("after_recen_data", rx_data, 8'h69);
        check("after_recen_rise", rise_cnt, 1);
        do_ack();

        // divider below 8 is ignored
        comp = 16'd5; rise_cnt = 0;
        send_frame(8'h00, 5, 1, 1'b0, -1, 0);
        idle(100);
        check("small_comp_ignored", rise_cnt, 0);
        comp = 16'd40;
        send_frame(8'hF0, 40, 1, 1'b0, -1, 0);
        idle(50);
        check("after_small_data", rx_data, 8'hF0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
